// File: rtl/pipelined_csel_adder.sv
// pipelined_csel_adder
// Two-stage pipelined carry-select adder/subtractor with valid/ready on both
// sides. Stage 1 forms speculative per-block ripple sums (carry-in 0 and 1).
// Stage 2 resolves the block-select chain and registers the result.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operands present
//   in_ready   block accepts operands this cycle
//   a, b       operands (WIDTH bits)
//   c_in       carry in (ignored when sub=1)
//   sub        0: a+b+c_in, 1: a-b
//   out_valid  result present
//   out_ready  consumer accepts result
//   sum        result (WIDTH bits, modulo 2^WIDTH)
//   c_out      carry out of MSB (subtract: 1 = no borrow)
//   ovf        two's-complement signed overflow
module pipelined_csel_adder #(
    parameter int WIDTH = 32'sd16,
    parameter int BLK   = 32'sd4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int NBLK = WIDTH / BLK;

    // BLK-bit ripple adder; returns {carry_out, sum}.
    function automatic logic [BLK:0] ripple_add(
        input logic [BLK-1:0] x,
        input logic [BLK-1:0] y,
        input logic           ci
    );
        logic [BLK-1:0] s;
        logic           c;
        s = '0;
        c = ci;
        for (int i = 0; i < BLK; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c, s};
    endfunction

    logic [WIDTH-1:0]           bb_s;
    logic                       cin0_s;
    logic [NBLK-1:0][BLK-1:0]   p_sum0_s;
    logic [NBLK-1:0][BLK-1:0]   p_sum1_s;
    logic [NBLK-1:0]            p_c0_s;
    logic [NBLK-1:0]            p_c1_s;

    logic                       adv1_s;
    logic                       adv2_s;
    logic                       accept_s;

    logic                       s1_valid_r;
    logic [NBLK-1:0][BLK-1:0]   s1_sum0_r;
    logic [NBLK-1:0][BLK-1:0]   s1_sum1_r;
    logic [NBLK-1:0]            s1_c0_r;
    logic [NBLK-1:0]            s1_c1_r;
    logic                       s1_a_msb_r;
    logic                       s1_bb_msb_r;

    logic [WIDTH-1:0]           res_sum_s;
    logic                       res_c_s;
    logic                       res_ovf_s;

    logic                       s2_valid_r;
    logic [WIDTH-1:0]           sum_r;
    logic                       c_out_r;
    logic                       ovf_r;

    // Pipeline advance: a stage may load when it is empty or its successor moves.
    assign adv2_s   = ~s2_valid_r | out_ready;
    assign adv1_s   = ~s1_valid_r | adv2_s;
    assign in_ready = rst_n & adv1_s;
    assign accept_s = in_valid & in_ready;

    // Operand prep and speculative per-block sums. Block 0 sees the real
    // carry-in on both branches, so its pair is identical and either select
    // yields the correct block-0 result.
    always_comb begin
        bb_s     = sub ? ~b : b;
        cin0_s   = sub ? 1'b1 : c_in;
        p_sum0_s = '0;
        p_sum1_s = '0;
        p_c0_s   = '0;
        p_c1_s   = '0;
        for (int k = 0; k < NBLK; k++) begin
            {p_c0_s[k], p_sum0_s[k]} = ripple_add(a[k*BLK +: BLK], bb_s[k*BLK +: BLK],
                                                  (k == 0) ? cin0_s : 1'b0);
            {p_c1_s[k], p_sum1_s[k]} = ripple_add(a[k*BLK +: BLK], bb_s[k*BLK +: BLK],
                                                  (k == 0) ? cin0_s : 1'b1);
        end
    end

    // Stage 1 registers: valid moves on advance, payload loads only on accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_r  <= 1'b0;
            s1_sum0_r   <= '0;
            s1_sum1_r   <= '0;
            s1_c0_r     <= '0;
            s1_c1_r     <= '0;
            s1_a_msb_r  <= 1'b0;
            s1_bb_msb_r <= 1'b0;
        end else begin
            if (adv1_s) begin
                s1_valid_r <= accept_s;
            end
            if (accept_s) begin
                s1_sum0_r   <= p_sum0_s;
                s1_sum1_r   <= p_sum1_s;
                s1_c0_r     <= p_c0_s;
                s1_c1_r     <= p_c1_s;
                s1_a_msb_r  <= a[WIDTH-1];
                s1_bb_msb_r <= bb_s[WIDTH-1];
            end
        end
    end

    // Carry-select chain: one mux per block, the selected carry picks the next pair.
    always_comb begin
        res_sum_s = '0;
        res_c_s   = 1'b0;
        for (int k = 0; k < NBLK; k++) begin
            if (res_c_s) begin
                res_sum_s[k*BLK +: BLK] = s1_sum1_r[k];
                res_c_s                 = s1_c1_r[k];
            end else begin
                res_sum_s[k*BLK +: BLK] = s1_sum0_r[k];
                res_c_s                 = s1_c0_r[k];
            end
        end
        res_ovf_s = (s1_a_msb_r == s1_bb_msb_r) & (res_sum_s[WIDTH-1] != s1_a_msb_r);
    end

    // Stage 2 / output registers: hold while stalled, load only real results.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
            sum_r      <= '0;
            c_out_r    <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            if (adv2_s) begin
                s2_valid_r <= s1_valid_r;
            end
            if (adv2_s & s1_valid_r) begin
                sum_r   <= res_sum_s;
                c_out_r <= res_c_s;
                ovf_r   <= res_ovf_s;
            end
        end
    end

    assign out_valid = s2_valid_r;
    assign sum       = sum_r;
    assign c_out     = c_out_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Testbench for pipelined_csel_adder: three instances (16/4, 32/8, 8/2) share
// operand inputs; only one instance is offered traffic at a time. Expected
// results come from a plain-arithmetic model pushed into a queue on accept.
module tb_pipelined_csel_adder;

    typedef struct {
        logic [31:0] sum;
        logic        c;
        logic        o;
    } res_t;

    logic        clk;
    logic        rst_n;
    logic [2:0]  in_valid_s;
    logic [2:0]  out_ready_s;
    logic [31:0] a_s;
    logic [31:0] b_s;
    logic        c_in_s;
    logic        sub_s;

    wire  [2:0]  in_ready_w;
    wire  [2:0]  out_valid_w;
    wire  [2:0]  c_out_w;
    wire  [2:0]  ovf_w;
    wire  [15:0] sum0_w;
    wire  [31:0] sum1_w;
    wire  [7:0]  sum2_w;

    int   n_tests;
    int   n_fail;
    res_t exp_q[$];

    pipelined_csel_adder #(.WIDTH(16), .BLK(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[0]), .in_ready(in_ready_w[0]),
        .a(a_s[15:0]), .b(b_s[15:0]), .c_in(c_in_s), .sub(sub_s),
        .out_valid(out_valid_w[0]), .out_ready(out_ready_s[0]),
        .sum(sum0_w), .c_out(c_out_w[0]), .ovf(ovf_w[0])
    );

    pipelined_csel_adder #(.WIDTH(32), .BLK(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[1]), .in_ready(in_ready_w[1]),
        .a(a_s), .b(b_s), .c_in(c_in_s), .sub(sub_s),
        .out_valid(out_valid_w[1]), .out_ready(out_ready_s[1]),
        .sum(sum1_w), .c_out(c_out_w[1]), .ovf(ovf_w[1])
    );

    pipelined_csel_adder #(.WIDTH(8), .BLK(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[2]), .in_ready(in_ready_w[2]),
        .a(a_s[7:0]), .b(b_s[7:0]), .c_in(c_in_s), .sub(sub_s),
        .out_valid(out_valid_w[2]), .out_ready(out_ready_s[2]),
        .sum(sum2_w), .c_out(c_out_w[2]), .ovf(ovf_w[2])
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int width_of(input int d);
        case (d)
            0:       return 16;
            1:       return 32;
            default: return 8;
        endcase
    endfunction

    function automatic logic [31:0] sum_of(input int d);
        case (d)
            0:       return {16'd0, sum0_w};
            1:       return sum1_w;
            default: return {24'd0, sum2_w};
        endcase
    endfunction

    function automatic logic [31:0] mask_of(input int w);
        logic [63:0] m;
        m = (64'd1 << w) - 64'd1;
        return m[31:0];
    endfunction

    // Reference: unsigned result/carry plus signed range check for overflow.
    function automatic res_t model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                   input logic ci, input logic su);
        res_t        r;
        logic [63:0] m;
        logic [63:0] ua;
        logic [63:0] ub;
        logic [63:0] tot;
        longint      lim;
        longint      sa;
        longint      sb;
        longint      sr;
        m   = (64'd1 << w) - 64'd1;
        ua  = {32'd0, av} & m;
        ub  = {32'd0, bv} & m;
        if (su) begin
            tot   = (ua - ub) & m;
            r.sum = tot[31:0];
            r.c   = (ua >= ub);
        end else begin
            tot   = ua + ub + {63'd0, ci};
            r.sum = 32'(tot & m);
            r.c   = tot[w];
        end
        lim = longint'(64'd1 << (w - 1));
        sa  = ua[w-1] ? longint'(ua) - 2 * lim : longint'(ua);
        sb  = ub[w-1] ? longint'(ub) - 2 * lim : longint'(ub);
        sr  = su ? (sa - sb) : (sa + sb + longint'({63'd0, ci}));
        r.o = (sr >= lim) || (sr < -lim);
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One clock cycle on instance d: drive at negedge, evaluate handshake,
    // push model result on accept, compare queue head on output transfer.
    task automatic step(input int d, input logic iv, input logic [31:0] av,
                        input logic [31:0] bv, input logic ci, input logic su,
                        input logic ordy, output logic acc, output logic xfer);
        res_t e;
        @(negedge clk);
        in_valid_s     = 3'b000;
        in_valid_s[d]  = iv;
        out_ready_s    = 3'b111;
        out_ready_s[d] = ordy;
        a_s            = av;
        b_s            = bv;
        c_in_s         = ci;
        sub_s          = su;
        #1;
        acc  = iv & in_ready_w[d];
        xfer = out_valid_w[d] & ordy;
        if (acc) begin
            exp_q.push_back(model(width_of(d), av, bv, ci, su));
        end
        if (xfer) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", {63'd0, xfer}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("sum", {32'd0, sum_of(d)}, {32'd0, e.sum});
                check("c_out", {63'd0, c_out_w[d]}, {63'd0, e.c});
                check("ovf", {63'd0, ovf_w[d]}, {63'd0, e.o});
            end
        end
    endtask

    task automatic drain(input int d);
        logic acc;
        logic xfer;
        for (int i = 0; i < 20 && (exp_q.size() > 0 || out_valid_w[d]); i++) begin
            step(d, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, acc, xfer);
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Directed single operation on the 16-bit instance with latency checks.
    task automatic do_one(input logic [31:0] av, input logic [31:0] bv, input logic ci,
                          input logic su, input logic [31:0] es, input logic ec,
                          input logic eo);
        logic acc;
        logic xfer;
        step(0, 1'b1, av, bv, ci, su, 1'b1, acc, xfer);
        check("dir_accept", {63'd0, acc}, 64'd1);
        step(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, acc, xfer);
        check("dir_lat1_valid", {63'd0, out_valid_w[0]}, 64'd0);
        step(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, acc, xfer);
        check("dir_lat2_valid", {63'd0, out_valid_w[0]}, 64'd1);
        check("dir_sum", {32'd0, sum_of(0)}, {32'd0, es});
        check("dir_c_out", {63'd0, c_out_w[0]}, {63'd0, ec});
        check("dir_ovf", {63'd0, ovf_w[0]}, {63'd0, eo});
    endtask

    // Directed sequence followed by throughput and randomized runs.
    initial begin
        logic        acc;
        logic        xfer;
        logic        need_new;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rc;
        logic        rs;
        int          n_acc;
        int          n_x;
        int          cyc;

        n_tests     = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        in_valid_s  = 3'b000;
        out_ready_s = 3'b111;
        a_s         = 32'd0;
        b_s         = 32'd0;
        c_in_s      = 1'b0;
        sub_s       = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_out_valid", {61'd0, out_valid_w}, 64'd0);
        check("rst_sum", {48'd0, sum0_w}, 64'd0);
        check("rst_c_out", {61'd0, c_out_w}, 64'd0);
        check("rst_ovf", {61'd0, ovf_w}, 64'd0);
        check("rst_in_ready_low", {61'd0, in_ready_w}, 64'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready_release", {61'd0, in_ready_w}, 64'd7);

        // Directed arithmetic cases on 16/4.
        do_one(32'hFFFF, 32'h0001, 1'b0, 1'b0, 32'h0000, 1'b1, 1'b0);
        do_one(32'h7FFF, 32'h0001, 1'b0, 1'b0, 32'h8000, 1'b0, 1'b1);
        do_one(32'h7FFF, 32'h0001, 1'b1, 1'b0, 32'h8001, 1'b0, 1'b1);
        do_one(32'h8000, 32'h0001, 1'b1, 1'b1, 32'h7FFF, 1'b1, 1'b1);
        do_one(32'h0003, 32'h0005, 1'b0, 1'b1, 32'hFFFE, 1'b0, 1'b0);
        drain(0);

        // Backpressure: out_ready low for 4 cycles, three pairs offered.
        step(0, 1'b1, 32'h1111, 32'h2222, 1'b0, 1'b0, 1'b0, acc, xfer);
        check("bp_acc0", {63'd0, acc}, 64'd1);
        step(0, 1'b1, 32'h0F0F, 32'h0101, 1'b0, 1'b0, 1'b0, acc, xfer);
        check("bp_acc1", {63'd0, acc}, 64'd1);
        for (int i = 0; i < 2; i++) begin
            step(0, 1'b1, 32'hABCD, 32'h1234, 1'b0, 1'b0, 1'b0, acc, xfer);
            check("bp_no_acc", {63'd0, acc}, 64'd0);
            check("bp_in_ready", {63'd0, in_ready_w[0]}, 64'd0);
            check("bp_hold_valid", {63'd0, out_valid_w[0]}, 64'd1);
            check("bp_hold_sum", {32'd0, sum_of(0)}, 64'h3333);
        end
        step(0, 1'b1, 32'hABCD, 32'h1234, 1'b0, 1'b0, 1'b1, acc, xfer);
        check("bp_release_acc", {63'd0, acc}, 64'd1);
        check("bp_release_xfer", {63'd0, xfer}, 64'd1);
        drain(0);

        // Reset mid-flight discards in-flight results.
        step(0, 1'b1, 32'h1234, 32'h1111, 1'b0, 1'b0, 1'b1, acc, xfer);
        step(0, 1'b1, 32'h0F0F, 32'h0F0F, 1'b0, 1'b0, 1'b1, acc, xfer);
        @(negedge clk);
        in_valid_s = 3'b000;
        rst_n      = 1'b0;
        #1;
        check("mrst_in_ready_low", {63'd0, in_ready_w[0]}, 64'd0);
        @(negedge clk);
        #1;
        check("mrst_out_valid", {63'd0, out_valid_w[0]}, 64'd0);
        check("mrst_sum", {32'd0, sum_of(0)}, 64'd0);
        check("mrst_c_out", {63'd0, c_out_w[0]}, 64'd0);
        check("mrst_ovf", {63'd0, ovf_w[0]}, 64'd0);
        rst_n = 1'b1;
        #1;
        check("mrst_in_ready_release", {63'd0, in_ready_w[0]}, 64'd1);
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            step(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1, acc, xfer);
            check("mrst_no_stale", {63'd0, out_valid_w[0]}, 64'd0);
        end

        for (int d = 0; d < 3; d++) begin
            // Full throughput: one result per cycle once the pipe is primed.
            n_acc = 0;
            n_x   = 0;
            for (int i = 0; i < 40; i++) begin
                ra = $urandom & mask_of(width_of(d));
                rb = $urandom & mask_of(width_of(d));
                step(d, 1'b1, ra, rb, 1'(($urandom >> 3) & 32'd1), 1'(($urandom >> 5) & 32'd1),
                     1'b1, acc, xfer);
                n_acc += int'(acc);
                n_x   += int'(xfer);
            end
            check("tput_acc", 64'(n_acc), 64'd40);
            check("tput_xfer", 64'(n_x), 64'd38);
            drain(d);

            // Random operands with random backpressure; operands held until accepted.
            n_acc    = 0;
            cyc      = 0;
            need_new = 1'b1;
            ra = 32'd0;
            rb = 32'd0;
            rc = 1'b0;
            rs = 1'b0;
            while (n_acc < 1000 && cyc < 5000) begin
                if (need_new) begin
                    ra = $urandom & mask_of(width_of(d));
                    rb = $urandom & mask_of(width_of(d));
                    rc = 1'($urandom_range(0, 1));
                    rs = 1'($urandom_range(0, 1));
                end
                step(d, 1'b1, ra, rb, rc, rs, 1'($urandom_range(0, 3) != 0), acc, xfer);
                need_new = acc;
                n_acc   += int'(acc);
                cyc++;
            end
            check("rand_accepted", 64'(n_acc), 64'd1000);
            drain(d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
